jtag_host_shifter: RTL

//  - JTAG initiator: drives TMS/TDI and samples TDO so that one IR or DR scan of LEN bits runs through a downstream TAP chain.
//  - Counterpart of the TAP-side data registers (bypass, boundary, user DRs), which consume Capture_DR/Shift_DR/Update_DR.
//  - Sits between the on-chip test sequencer (command side) and the JTAG pins (TAP side).

---
 rtl/jtag_pkg.sv | 59 +++++
 rtl/jtag_tap_mirror.sv | 21 ++
 rtl/jtag_host_shifter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// Shared JTAG types: IEEE 1149.1 TAP state encoding, host FSM states and the TAP
// next-state function used by host and TAP-side blocks.
package jtag_pkg;

   typedef enum logic [3:0] {
      TAP_EXIT2_DR   = 4'h0,
      TAP_EXIT1_DR   = 4'h1,
      TAP_SHIFT_DR   = 4'h2,
      TAP_PAUSE_DR   = 4'h3,
      TAP_SELECT_IR  = 4'h4,
      TAP_UPDATE_DR  = 4'h5,
      TAP_CAPTURE_DR = 4'h6,
      TAP_SELECT_DR  = 4'h7,
      TAP_EXIT2_IR   = 4'h8,
      TAP_EXIT1_IR   = 4'h9,
      TAP_SHIFT_IR   = 4'hA,
      TAP_PAUSE_IR   = 4'hB,
      TAP_RTI        = 4'hC,
      TAP_UPDATE_IR  = 4'hD,
      TAP_CAPTURE_IR = 4'hE,
      TAP_TLR        = 4'hF
   } tap_state_t;

   typedef enum logic [2:0] {
      HS_RESET_SEQ = 3'd0,
      HS_IDLE      = 3'd1,
      HS_SEL       = 3'd2,
      HS_CAPTURE   = 3'd3,
      HS_SHIFT     = 3'd4,
      HS_UPDATE    = 3'd5,
      HS_RTI       = 3'd6
   } host_state_t;

   // TMS=1 edges that force any TAP into Test-Logic-Reset
   localparam int unsigned RESET_TMS_ONES = 5;

   function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
      tap_next = TAP_TLR;
      case (s)
         TAP_TLR:        tap_next = tms ? TAP_TLR       : TAP_RTI;
         TAP_RTI:        tap_next = tms ? TAP_SELECT_DR : TAP_RTI;
         TAP_SELECT_DR:  tap_next = tms ? TAP_SELECT_IR : TAP_CAPTURE_DR;
         TAP_CAPTURE_DR: tap_next = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
         TAP_SHIFT_DR:   tap_next = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
         TAP_EXIT1_DR:   tap_next = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
         TAP_PAUSE_DR:   tap_next = tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
         TAP_EXIT2_DR:   tap_next = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
         TAP_UPDATE_DR:  tap_next = tms ? TAP_SELECT_DR : TAP_RTI;
         TAP_SELECT_IR:  tap_next = tms ? TAP_TLR       : TAP_CAPTURE_IR;
         TAP_CAPTURE_IR: tap_next = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
         TAP_SHIFT_IR:   tap_next = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
         TAP_EXIT1_IR:   tap_next = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
         TAP_PAUSE_IR:   tap_next = tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
         TAP_EXIT2_IR:   tap_next = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
         TAP_UPDATE_IR:  tap_next = tms ? TAP_SELECT_DR : TAP_RTI;
      endcase
   endfunction

endpackage

// File: rtl/jtag_tap_mirror.sv
// 16-state IEEE 1149.1 TAP controller tracking TMS on rising TCK; shared by host
// and TAP-side blocks.
module jtag_tap_mirror
   import jtag_pkg::*;
(
   input  logic       TCK,
   input  logic       RST,
   input  logic       TMS,
   output logic [3:0] tap_state
);

   tap_state_t state_q;

   always_ff @(posedge TCK or posedge RST) begin
      if (RST) state_q <= TAP_TLR;
      else     state_q <= tap_next(state_q, TMS);
   end

   assign tap_state = state_q;

endmodule

// File: rtl/jtag_host_shifter.sv
// JTAG initiator running one IR or DR scan of len bits through a TAP chain.
// Optional TAP monitor ports (tap_state, tap_err) under `JTAG_HOST_TAP_MON_EN.
module jtag_host_shifter
   import jtag_pkg::*;
#(
   parameter  int unsigned MAX_LEN = 32,
   localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               TCK,
   input  logic               RST,
   input  logic               start,
   input  logic               ir_sel,
   input  logic [LEN_W-1:0]   len,
   input  logic [MAX_LEN-1:0] data_in,
   output logic               busy,
   output logic               done,
   output logic [MAX_LEN-1:0] data_out,
   output logic               TMS,
   input  logic               TDO,
`ifdef JTAG_HOST_TAP_MON_EN
   output logic [3:0]         tap_state,
   output logic               tap_err,
`endif
   output logic               TDI
);

   host_state_t        state, state_next;
   logic [LEN_W-1:0]   cnt, len_q, len_sat;
   logic               ir_q, last_bit, tms_c, tdi_c;
   logic [MAX_LEN-1:0] tdi_q, cap_q;
   logic [3:0]         mir_raw;
   tap_state_t         mir_state, tap_nxt;

   jtag_tap_mirror u_mirror (
      .TCK       (TCK),
      .RST       (RST),
      .TMS       (TMS),
      .tap_state (mir_raw)
   );

   // tap_nxt is where the chain lands on the coming rising edge
   assign mir_state = tap_state_t'(mir_raw);
   assign tap_nxt   = tap_next(mir_state, TMS);
   assign len_sat   = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
   assign last_bit  = (cnt == len_q - LEN_W'(1));

   always_ff @(posedge TCK or posedge RST) begin
      if (RST) state <= HS_RESET_SEQ;
      else     state <= state_next;
   end

   // SEL/CAPTURE are left on the mirror, so IR gets its extra Select edge for free
   always_comb begin
      state_next = state;
      case (state)
         HS_RESET_SEQ: if (cnt == LEN_W'(RESET_TMS_ONES)) state_next = HS_IDLE;
         HS_IDLE:      if (start && (len_sat != '0)) state_next = HS_SEL;
         HS_SEL:       if (tap_nxt == (ir_q ? TAP_SELECT_IR : TAP_SELECT_DR))
                          state_next = HS_CAPTURE;
         HS_CAPTURE:   if (tap_nxt == (ir_q ? TAP_SHIFT_IR : TAP_SHIFT_DR))
                          state_next = HS_SHIFT;
         HS_SHIFT:     if (last_bit) state_next = HS_UPDATE;
         HS_UPDATE:    state_next = HS_RTI;
         HS_RTI:       state_next = HS_IDLE;
         default:      state_next = HS_RESET_SEQ;
      endcase
   end

   // TMS/TDI to present on the next rising edge
   always_comb begin
      tms_c = 1'b0;
      tdi_c = 1'b0;
      case (state)
         HS_RESET_SEQ: tms_c = (cnt < LEN_W'(RESET_TMS_ONES));
         HS_SEL:       tms_c = 1'b1;
         HS_SHIFT: begin
            tms_c = last_bit;
            tdi_c = tdi_q[0];
         end
         HS_UPDATE:    tms_c = 1'b1;
         default:      ;
      endcase
   end

   always_ff @(negedge TCK or posedge RST) begin
      if (RST) begin
         TMS <= 1'b1;
         TDI <= 1'b0;
      end else begin
         TMS <= tms_c;
         TDI <= tdi_c;
      end
   end

   always_ff @(posedge TCK or posedge RST) begin
      if (RST) begin
         cnt      <= '0;
         len_q    <= '0;
         ir_q     <= 1'b0;
         tdi_q    <= '0;
         cap_q    <= '0;
         data_out <= '0;
         busy     <= 1'b1;
         done     <= 1'b0;
      end else begin
         busy <= (state_next != HS_IDLE);
         done <= 1'b0;
         case (state)
            HS_RESET_SEQ: cnt <= cnt + LEN_W'(1);
            HS_IDLE: if (start) begin
               cnt   <= '0;
               len_q <= len_sat;
               ir_q  <= ir_sel;
               tdi_q <= data_in;
               cap_q <= '0;
               if (len_sat == '0) done <= 1'b1;
            end
            HS_SHIFT: begin
               cnt   <= cnt + LEN_W'(1);
               tdi_q <= tdi_q >> 1;
               cap_q <= {TDO, cap_q[MAX_LEN-1:1]};
            end
            // first bit captured sits at MAX_LEN-len; realign it to bit 0
            HS_RTI: begin
               done     <= 1'b1;
               data_out <= cap_q >> (LEN_W'(MAX_LEN) - len_q);
            end
            default: ;
         endcase
      end
   end

`ifdef JTAG_HOST_TAP_MON_EN
   assign tap_state = mir_raw;

   always_ff @(posedge TCK or posedge RST) begin
      if (RST)                                                 tap_err <= 1'b0;
      else if ((state_next == HS_IDLE) && (tap_nxt != TAP_RTI)) tap_err <= 1'b1;
   end
`endif

endmodule
